onehot_reg_bank: RTL and testbench
==================================

# onehot_reg_bank

8-entry register bank written through a one-hot select vector: the 8-bit one-hot code produced by the 3-to-8 decoder stage drives WR_SEL directly. Two independent registered read ports are addressed by binary 3-bit indices. Malformed select vectors are detected and blocked, and a sticky error flag records them. The bank also tracks which entries have been written since reset and counts accepted writes. It is the storage stage of the summer-campus CPU datapath.

## Interface
Parameters:
- WIDTH, 8, data width of each register and of the read/write data buses.

Ports:
- CLK  input  1  sole clock; all state updates on its rising edge.
- RST_N  input  1  reset, asynchronous assert, active-low; clears all state.
- WR_EN  input  1  write strobe, sampled on the CLK rising edge.
- WR_SEL  input  8  one-hot register select; bit i selects register i.
- WR_DATA  input  WIDTH  write data.
- RD_ADDR_A  input  3  binary read index, port A.
- RD_ADDR_B  input  3  binary read index, port B.
- ERR_CLR  input  1  synchronous clear of SEL_ERR.
- RD_DATA_A  output  WIDTH  registered read data, port A.
- RD_DATA_B  output  WIDTH  registered read data, port B.
- VALID_MASK  output  8  bit i = register i written since reset.
- SEL_ERR  output  1  sticky malformed-select flag.
- WR_COUNT  output  8  accepted-write counter, saturating.

## Operation
- Storage: 8 registers of WIDTH bits. All are 0 after reset.
- A write is accepted when WR_EN=1 and WR_SEL has exactly one bit set. The selected register loads WR_DATA, VALID_MASK[i] is set, and WR_COUNT increments.
- Malformed select: WR_EN=1 and WR_SEL is 8'h00 or has two or more bits set.
  - No register, VALID_MASK bit, or WR_COUNT changes.
  - SEL_ERR is set to 1.
- WR_EN=0: WR_SEL is ignored entirely. SEL_ERR does not change, even for a malformed WR_SEL.
- SEL_ERR is sticky until ERR_CLR=1 is sampled. If a malformed write and ERR_CLR occur in the same cycle, the set wins and SEL_ERR stays 1.
- WR_COUNT saturates at 8'hFF. Further accepted writes still update registers; the count holds at 8'hFF.
- VALID_MASK bits only set. Only reset clears them.
- Read ports are write-first. On each edge, RD_DATA_x loads register[RD_ADDR_x] as it stands after that edge's write. A same-cycle write to the addressed register therefore returns WR_DATA, not the old value.
- Both ports may address the same register, including one being written. Both then return identical data.

## Timing
- Write latency: data is stored on the edge where WR_EN is sampled. It is readable on the next RD_DATA update, or on the same edge through the write-first path.
- Read latency: 1 cycle. RD_ADDR_x is sampled at edge k, and RD_DATA_x is valid after edge k and held until edge k+1.
- No combinational path exists from any input to any output.
- Reset:
  - RST_N low immediately forces registers, RD_DATA_A, RD_DATA_B, VALID_MASK, SEL_ERR and WR_COUNT to 0, without waiting for CLK.
  - Reset asserted during an active write discards that write.
  - On the first rising edge after RST_N deasserts, normal operation resumes. A write and a read presented on that edge take effect.
- SEL_ERR and WR_COUNT update on the same edge as the write attempt that affects them.

## Test plan
- Reset mid-write: hold WR_EN=1, WR_SEL=8'h04, WR_DATA=8'h5A and pulse RST_N low between edges -> all outputs are 0 immediately. Register 2 stays 0 after RST_N is released with WR_EN=0.
- Fill and read back: write register i = 8'h10+i for i=0..7 using WR_SEL=1<<i, then sweep RD_ADDR_A and RD_ADDR_B through opposite orders -> each port returns 8'h10+addr one cycle after its address. Final state: VALID_MASK=8'hFF, WR_COUNT=8, SEL_ERR=0.
- Write-first bypass: register 3 holds 8'h33. Write 8'hC3 to WR_SEL=8'h08 with RD_ADDR_A=RD_ADDR_B=3 in the same cycle -> both RD_DATA outputs read 8'hC3 after that edge.
- Malformed selects:
  - WR_EN=1 with WR_SEL=8'h00, then WR_SEL=8'h81 -> no register changes, WR_COUNT unchanged, SEL_ERR=1.
  - WR_EN=0 with WR_SEL=8'h03 -> SEL_ERR unchanged.
  - ERR_CLR=1 alone -> SEL_ERR=0.
  - Malformed write with ERR_CLR=1 in the same cycle -> SEL_ERR=1.
- Counter saturation: 260 accepted writes to rotating registers -> WR_COUNT reaches 8'hFF and holds there. The last written data is still readable at its register.

Source files
------------

// File: rtl/onehot_reg_bank.sv
// onehot_reg_bank: 8-entry register bank with one-hot write select, malformed-select guard and write-first read ports
module onehot_reg_bank #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             WR_EN,
    input  logic [7:0]       WR_SEL,
    input  logic [WIDTH-1:0] WR_DATA,
    input  logic [2:0]       RD_ADDR_A,
    input  logic [2:0]       RD_ADDR_B,
    input  logic             ERR_CLR,
    output logic [WIDTH-1:0] RD_DATA_A,
    output logic [WIDTH-1:0] RD_DATA_B,
    output logic [7:0]       VALID_MASK,
    output logic             SEL_ERR,
    output logic [7:0]       WR_COUNT
);
    logic [WIDTH-1:0] regs [8];
    logic one_hot;
    logic wr_ok;
    logic wr_bad;

    assign one_hot = (WR_SEL != 8'h00) && ((WR_SEL & (WR_SEL - 8'd1)) == 8'h00);
    assign wr_ok   = WR_EN && one_hot;
    assign wr_bad  = WR_EN && !one_hot;

    // storage and written-entry tracking; only a well-formed one-hot write touches them
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            VALID_MASK <= 8'h00;
        end else if (wr_ok) begin
            for (int i = 0; i < 8; i++) if (WR_SEL[i]) regs[i] <= WR_DATA;
            VALID_MASK <= VALID_MASK | WR_SEL;
        end
    end

    // registered read ports; a same-edge write to the addressed entry is forwarded
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RD_DATA_A <= '0;
            RD_DATA_B <= '0;
        end else begin
            RD_DATA_A <= (wr_ok && WR_SEL[RD_ADDR_A]) ? WR_DATA : regs[RD_ADDR_A];
            RD_DATA_B <= (wr_ok && WR_SEL[RD_ADDR_B]) ? WR_DATA : regs[RD_ADDR_B];
        end
    end

    // sticky select error (set beats clear) and saturating accepted-write counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            SEL_ERR  <= 1'b0;
            WR_COUNT <= 8'h00;
        end else begin
            SEL_ERR  <= wr_bad ? 1'b1 : (ERR_CLR ? 1'b0 : SEL_ERR);
            WR_COUNT <= (wr_ok && WR_COUNT != 8'hFF) ? WR_COUNT + 8'd1 : WR_COUNT;
        end
    end
endmodule

// File: tb/tb_onehot_reg_bank.sv
// tb_onehot_reg_bank: directed and random checks of onehot_reg_bank against a behavioural model
module tb_onehot_reg_bank;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       WR_EN = 1'b0;
    logic [7:0] WR_SEL = 8'h00;
    logic [7:0] WR_DATA = 8'h00;
    logic [2:0] RD_ADDR_A = 3'd0;
    logic [2:0] RD_ADDR_B = 3'd0;
    logic       ERR_CLR = 1'b0;
    logic [7:0] RD_DATA_A;
    logic [7:0] RD_DATA_B;
    logic [7:0] VALID_MASK;
    logic       SEL_ERR;
    logic [7:0] WR_COUNT;

    int tests = 0;
    int failed = 0;

    logic [7:0] m_regs [8];
    logic [7:0] m_valid;
    logic       m_err;
    int         m_cnt;
    logic [7:0] m_rda;
    logic [7:0] m_rdb;

    onehot_reg_bank #(.WIDTH(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .WR_SEL(WR_SEL), .WR_DATA(WR_DATA),
        .RD_ADDR_A(RD_ADDR_A), .RD_ADDR_B(RD_ADDR_B), .ERR_CLR(ERR_CLR),
        .RD_DATA_A(RD_DATA_A), .RD_DATA_B(RD_DATA_B), .VALID_MASK(VALID_MASK),
        .SEL_ERR(SEL_ERR), .WR_COUNT(WR_COUNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ":rd_a"}, {24'h0, RD_DATA_A}, {24'h0, m_rda});
        chk({tag, ":rd_b"}, {24'h0, RD_DATA_B}, {24'h0, m_rdb});
        chk({tag, ":valid"}, {24'h0, VALID_MASK}, {24'h0, m_valid});
        chk({tag, ":err"}, {31'h0, SEL_ERR}, {31'h0, m_err});
        chk({tag, ":count"}, {24'h0, WR_COUNT}, m_cnt);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_valid = 8'h00;
        m_err = 1'b0;
        m_cnt = 0;
        m_rda = 8'h00;
        m_rdb = 8'h00;
    endtask

    task automatic step(input string tag, input logic en, input logic [7:0] sel, input logic [7:0] data,
                        input logic [2:0] aa, input logic [2:0] ab, input logic clr);
        WR_EN = en; WR_SEL = sel; WR_DATA = data; RD_ADDR_A = aa; RD_ADDR_B = ab; ERR_CLR = clr;
        @(posedge CLK);
        if (en && $countones(sel) == 1) begin
            for (int i = 0; i < 8; i++) if (sel[i]) begin m_regs[i] = data; m_valid[i] = 1'b1; end
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
        if (en && $countones(sel) != 1) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        m_rda = m_regs[aa];
        m_rdb = m_regs[ab];
        #1 chk_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1 chk_all("reset");
        @(negedge CLK) RST_N = 1'b1;
        step("idle", 0, 8'h00, 8'h00, 3'd0, 3'd0, 0);
        step("pre_w2", 1, 8'h04, 8'h77, 3'd2, 3'd2, 0);
        // reset mid-write
        WR_EN = 1'b1; WR_SEL = 8'h04; WR_DATA = 8'h5A;
        @(negedge CLK) RST_N = 1'b0;
        model_reset();
        #1 chk_all("rst_async");
        @(posedge CLK);
        #1 chk_all("rst_hold");
        @(negedge CLK) begin WR_EN = 1'b0; RST_N = 1'b1; end
        step("rst_rel", 0, 8'h04, 8'h5A, 3'd2, 3'd2, 0);
        chk("rst_reg2", {24'h0, RD_DATA_A}, 32'h0);
        // fill and read back
        for (int i = 0; i < 8; i++) step("fill", 1, 8'(1 << i), 8'(8'h10 + i), 3'(7 - i), 3'(i), 0);
        for (int i = 0; i < 8; i++) begin
            step("sweep", 0, 8'h00, 8'h00, 3'(i), 3'(7 - i), 0);
            chk("sweep_a", {24'h0, RD_DATA_A}, 32'h10 + i);
            chk("sweep_b", {24'h0, RD_DATA_B}, 32'h17 - i);
        end
        chk("fill_valid", {24'h0, VALID_MASK}, 32'hFF);
        chk("fill_count", {24'h0, WR_COUNT}, 32'd8);
        // write-first bypass
        step("byp_pre", 1, 8'h08, 8'h33, 3'd0, 3'd0, 0);
        step("bypass", 1, 8'h08, 8'hC3, 3'd3, 3'd3, 0);
        chk("bypass_a", {24'h0, RD_DATA_A}, 32'hC3);
        chk("bypass_b", {24'h0, RD_DATA_B}, 32'hC3);
        // malformed selects
        step("bad_zero", 1, 8'h00, 8'hEE, 3'd0, 3'd7, 0);
        step("bad_two", 1, 8'h81, 8'hEE, 3'd0, 3'd7, 0);
        chk("bad_err", {31'h0, SEL_ERR}, 32'd1);
        chk("bad_a", {24'h0, RD_DATA_A}, 32'h10);
        step("dis_bad", 0, 8'h03, 8'hEE, 3'd1, 3'd1, 0);
        chk("dis_err", {31'h0, SEL_ERR}, 32'd1);
        step("clr", 0, 8'h00, 8'h00, 3'd1, 3'd1, 1);
        chk("clr_err", {31'h0, SEL_ERR}, 32'd0);
        step("set_win", 1, 8'h06, 8'hEE, 3'd1, 3'd2, 1);
        chk("set_win_err", {31'h0, SEL_ERR}, 32'd1);
        step("clr2", 0, 8'h00, 8'h00, 3'd0, 3'd0, 1);
        // counter saturation
        for (int i = 0; i < 260; i++)
            step("sat", 1, 8'(1 << (i % 8)), 8'($urandom), 3'($urandom_range(0, 7)), 3'((i + 1) % 8), 0);
        chk("sat_count", {24'h0, WR_COUNT}, 32'hFF);
        step("sat_read", 0, 8'h00, 8'h00, 3'd3, 3'd3, 0);
        chk("sat_last", {24'h0, RD_DATA_A}, {24'h0, m_regs[3]});
        // random traffic
        for (int n = 0; n < 300; n++) begin
            logic [7:0] s;
            int k;
            k = $urandom_range(0, 3);
            s = (k < 2) ? 8'(1 << $urandom_range(0, 7)) : (k == 2) ? 8'($urandom) : 8'h00;
            step("rand", 1'($urandom), s, 8'($urandom), 3'($urandom), 3'($urandom), $urandom_range(0, 7) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
